// File: rtl/sample_framer.sv
// Frames a strobed microphone sample stream into a two-bank ping-pong buffer
// and streams each completed frame out over valid/ready with index/last markers.
module sample_framer #(
    parameter int FRAME_LEN = 256,
    parameter bit CENTER    = 1'b1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         sample_tick,
    input  logic [15:0]                  time_domain,
    output logic [15:0]                  out_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [$clog2(FRAME_LEN)-1:0] out_index,
    output logic                         out_last,
    output logic                         overflow,
    input  logic                         clear_overflow,
    output logic [15:0]                  frames_done
);

    localparam int IW = $clog2(FRAME_LEN);
    localparam logic [IW-1:0] LAST = IW'(FRAME_LEN - 1);

    typedef enum logic {
        IDLE,
        STREAM
    } state_t;

    state_t state;

    logic [15:0]   bank [2][FRAME_LEN];
    logic [IW-1:0] wp;
    logic [IW-1:0] rp;
    logic [IW-1:0] rp_next;
    logic          wb;
    logic          rb;
    logic          rb_next;
    logic [1:0]    bank_full;
    logic [1:0]    bank_full_next;
    logic [15:0]   converted;
    logic          wr_en;
    logic          drop;
    logic          xfer;
    logic          wr_done;
    logic          rd_done;

    // Re-centring flips the ADC MSB and sign-extends: 0x800 maps to zero.
    always_comb begin
        converted = time_domain;
        if (CENTER) begin
            converted = {{4{~time_domain[11]}}, ~time_domain[11], time_domain[10:0]};
        end
    end

    // Writer and reader always target different banks when both finish a frame,
    // so the two bank_full updates never collide.
    always_comb begin
        wr_en          = sample_tick & ~bank_full[wb];
        drop           = sample_tick & bank_full[wb];
        xfer           = out_valid & out_ready;
        wr_done        = wr_en && (wp == LAST);
        rd_done        = xfer && (rp == LAST);
        bank_full_next = bank_full;
        if (wr_done) begin
            bank_full_next[wb] = 1'b1;
        end
        if (rd_done) begin
            bank_full_next[rb] = 1'b0;
        end
        rb_next = rd_done ? ~rb : rb;
        rp_next = rp;
        if (rd_done) begin
            rp_next = '0;
        end else if (xfer) begin
            rp_next = rp + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            bank[wb][wp] <= converted;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            wp          <= '0;
            wb          <= 1'b0;
            rp          <= '0;
            rb          <= 1'b0;
            bank_full   <= 2'b00;
            out_last    <= 1'b0;
            overflow    <= 1'b0;
            frames_done <= 16'd0;
        end else begin
            if (wr_en) begin
                wp <= wr_done ? '0 : wp + 1'b1;
            end
            if (wr_done) begin
                wb <= ~wb;
            end
            bank_full <= bank_full_next;
            rb        <= rb_next;
            rp        <= rp_next;
            if (rd_done) begin
                frames_done <= frames_done + 16'd1;
            end
            if (drop) begin
                overflow <= 1'b1;
            end else if (clear_overflow) begin
                overflow <= 1'b0;
            end
            case (state)
                IDLE: begin
                    if (bank_full_next[rb_next]) begin
                        state <= STREAM;
                    end
                end
                STREAM: begin
                    if (!bank_full_next[rb_next]) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
            out_last <= bank_full_next[rb_next] && (rp_next == LAST);
        end
    end

    assign out_valid = (state == STREAM);
    assign out_index = rp;
    assign out_data  = bank[rb][rp];

endmodule

// File: tb/tb_sample_framer.sv
// Randomised scoreboard bench: a frame-level reference model feeds an expected
// beat queue that a negedge monitor compares against a centred and a raw DUT.
module tb_sample_framer;

    localparam int FRAME_LEN = 4;
    localparam int IW        = 2;

    logic          clk            = 1'b0;
    logic          rst            = 1'b0;
    logic          sample_tick    = 1'b0;
    logic [15:0]   time_domain    = 16'd0;
    logic          out_ready      = 1'b0;
    logic          clear_overflow = 1'b0;

    logic [15:0]   c_data;
    logic          c_valid;
    logic [IW-1:0] c_index;
    logic          c_last;
    logic          c_overflow;
    logic [15:0]   c_frames;

    logic [15:0]   r_data;
    logic          r_valid;
    logic [IW-1:0] r_index;
    logic          r_last;
    logic          r_overflow;
    logic [15:0]   r_frames;

    typedef struct {
        logic [15:0] centered;
        logic [15:0] raw;
        int          index;
        bit          last;
    } beat_t;

    beat_t       exp_q[$];
    logic [15:0] part_c[$];
    logic [15:0] part_r[$];
    int          full_count = 0;
    int          beat_pos   = 0;
    int          pre_full   = 0;
    bit          exp_ovf    = 1'b0;
    int          exp_frames = 0;
    int          checks     = 0;
    int          passes     = 0;
    beat_t       mon_e;
    beat_t       new_beat;

    sample_framer #(.FRAME_LEN(FRAME_LEN), .CENTER(1'b1)) u_centered (
        .clk(clk), .rst(rst), .sample_tick(sample_tick), .time_domain(time_domain),
        .out_data(c_data), .out_valid(c_valid), .out_ready(out_ready),
        .out_index(c_index), .out_last(c_last), .overflow(c_overflow),
        .clear_overflow(clear_overflow), .frames_done(c_frames)
    );

    sample_framer #(.FRAME_LEN(FRAME_LEN), .CENTER(1'b0)) u_raw (
        .clk(clk), .rst(rst), .sample_tick(sample_tick), .time_domain(time_domain),
        .out_data(r_data), .out_valid(r_valid), .out_ready(out_ready),
        .out_index(r_index), .out_last(r_last), .overflow(r_overflow),
        .clear_overflow(clear_overflow), .frames_done(r_frames)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] center(input logic [15:0] td);
        int v;
        v = int'(td[11:0]) - 2048;
        return v[15:0];
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual === expected) begin
            passes++;
        end else begin
            $display("[TB] FAIL %s: got %0h, required %0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [15:0] td);
        sample_tick = 1'b1;
        time_domain = td;
        @(posedge clk);
        #1;
        sample_tick = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_valid"}, 32'(c_valid), 32'd0);
        checkOutput({tag, "_last"}, 32'(c_last), 32'd0);
        checkOutput({tag, "_index"}, 32'(c_index), 32'd0);
        checkOutput({tag, "_overflow"}, 32'(c_overflow), 32'd0);
        checkOutput({tag, "_frames"}, 32'(c_frames), 32'd0);
        checkOutput({tag, "_raw_valid"}, 32'(r_valid), 32'd0);
    endtask

    // Model tracks how many frames are complete but unreleased; a tick is only
    // dropped when both banks are occupied as seen before the edge.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            exp_q.delete();
            part_c.delete();
            part_r.delete();
            full_count = 0;
            beat_pos   = 0;
            exp_ovf    = 1'b0;
            exp_frames = 0;
        end else begin
            pre_full = full_count;
            if (pre_full > 0 && out_ready) begin
                beat_pos++;
                if (beat_pos == FRAME_LEN) begin
                    beat_pos   = 0;
                    full_count--;
                    exp_frames = (exp_frames + 1) % 65536;
                end
            end
            if (sample_tick && pre_full < 2) begin
                part_c.push_back(center(time_domain));
                part_r.push_back(time_domain);
                if (part_c.size() == FRAME_LEN) begin
                    for (int i = 0; i < FRAME_LEN; i++) begin
                        new_beat.centered = part_c[i];
                        new_beat.raw      = part_r[i];
                        new_beat.index    = i;
                        new_beat.last     = (i == FRAME_LEN - 1);
                        exp_q.push_back(new_beat);
                    end
                    part_c.delete();
                    part_r.delete();
                    full_count++;
                end
            end
            if (sample_tick && pre_full == 2) begin
                exp_ovf = 1'b1;
            end else if (clear_overflow) begin
                exp_ovf = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            checkOutput("valid", 32'(c_valid), 32'(full_count > 0));
            checkOutput("raw_valid", 32'(r_valid), 32'(full_count > 0));
            checkOutput("overflow", 32'(c_overflow), 32'(exp_ovf));
            checkOutput("frames_done", 32'(c_frames), 32'(exp_frames));
            if (c_valid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    $display("[TB] FAIL unexpected_beat: got data %0h index %0d, required no beat", c_data, c_index);
                end else begin
                    mon_e = exp_q[0];
                    checkOutput("data", 32'(c_data), 32'(mon_e.centered));
                    checkOutput("raw_data", 32'(r_data), 32'(mon_e.raw));
                    checkOutput("index", 32'(c_index), 32'(mon_e.index));
                    checkOutput("last", 32'(c_last), 32'(mon_e.last));
                    if (out_ready) begin
                        mon_e = exp_q.pop_front();
                    end
                end
            end else begin
                checkOutput("last_idle", 32'(c_last), 32'd0);
            end
        end
    end

    initial begin
        #2 rst = 1'b1;
        #1 checkResetOutputs("reset");
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        out_ready = 1'b1;
        applyStimulus(16'h0000);
        applyStimulus(16'h0800);
        applyStimulus(16'h0FFF);
        applyStimulus(16'h0801);
        checkOutput("first_valid", 32'(c_valid), 32'd1);
        idle(6);
        checkOutput("first_frames", 32'(c_frames), 32'd1);

        applyStimulus(16'h1234);
        applyStimulus(16'hABCD);
        applyStimulus(16'h0000);
        applyStimulus(16'hFFFF);
        idle(6);

        out_ready = 1'b0;
        repeat (4) applyStimulus(16'($urandom));
        out_ready = 1'b1;
        idle(2);
        out_ready = 1'b0;
        idle(3);
        checkOutput("hold_index", 32'(c_index), 32'd2);
        idle(2);
        out_ready = 1'b1;
        idle(4);

        out_ready = 1'b0;
        repeat (8) applyStimulus(16'($urandom));
        out_ready = 1'b1;
        idle(10);
        checkOutput("pingpong_overflow", 32'(c_overflow), 32'd0);
        checkOutput("pingpong_frames", 32'(c_frames), 32'd5);

        out_ready = 1'b0;
        repeat (9) applyStimulus(16'($urandom));
        checkOutput("overflow_set", 32'(c_overflow), 32'd1);
        clear_overflow = 1'b1;
        idle(1);
        clear_overflow = 1'b0;
        checkOutput("overflow_cleared", 32'(c_overflow), 32'd0);
        out_ready = 1'b1;
        idle(12);

        out_ready = 1'b0;
        repeat (4) applyStimulus(16'($urandom));
        out_ready = 1'b1;
        idle(1);
        out_ready = 1'b0;
        repeat (2) applyStimulus(16'($urandom));
        #2 rst = 1'b1;
        #1 checkResetOutputs("midreset");
        rst = 1'b0;
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        repeat (4) applyStimulus(16'($urandom));
        idle(6);
        checkOutput("midreset_frames", 32'(c_frames), 32'd1);

        for (int i = 0; i < 80; i++) begin
            sample_tick    = ($urandom_range(0, 3) != 0);
            time_domain    = 16'($urandom);
            out_ready      = ($urandom_range(0, 3) != 0);
            clear_overflow = ($urandom_range(0, 7) == 0);
            @(posedge clk);
            #1;
        end
        sample_tick    = 1'b0;
        clear_overflow = 1'b0;
        out_ready      = 1'b1;

        for (int i = 0; i < 100 && exp_q.size() != 0; i++) begin
            idle(1);
        end
        checkOutput("drain_empty", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
